// File: rtl/encoder_proj_if.sv
// Valid/ready handshake bundle between the data source, the Hamming(7,4) encoder
// and the downstream decoder.
interface encoder_proj_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] io_out;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, io_out, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, io_out, out_valid
  );
endinterface

// File: rtl/encoder_proj.sv
// Hamming(7,4) transmit encoder: input FIFO, registered codeword output and a
// walking single-bit error injector for exercising the decoder's correction path.
module encoder_proj #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  encoder_proj_if.slave            bus,
  input  logic                     inject_en,
  output logic [15:0]              word_count,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  function automatic logic [6:0] inject_mask(input logic [2:0] idx);
    return 7'b0000001 << idx;
  endfunction

  logic [3:0]    mem_p0 [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic [6:0]    head_code_p0;
  logic [6:0]    code_p1;
  logic          vld_p1;
  logic [2:0]    inj_idx;

  // Stage p0: FIFO; pop decision uses the pre-push level, so no bypass exists
  assign full         = (fifo_level == FULL_LVL);
  assign empty        = (fifo_level == '0);
  assign push         = bus.in_valid && !full;
  assign pop          = (!vld_p1 || bus.out_ready) && !empty;
  assign head_code_p0 = hamming_encode(mem_p0[rd_ptr]);

  assign bus.in_ready  = !full;
  assign bus.io_out    = code_p1;
  assign bus.out_valid = vld_p1;

  always_ff @(posedge clock) begin
    if (push) mem_p0[wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Stage p1: output register; a load on a handshake cycle replaces the word bubble-free
  always_ff @(posedge clock) begin
    if (reset) begin
      code_p1    <= '0;
      vld_p1     <= 1'b0;
      inj_idx    <= '0;
      word_count <= '0;
    end else begin
      if (vld_p1 && bus.out_ready) word_count <= word_count + 16'd1;
      if (pop) begin
        vld_p1 <= 1'b1;
        if (inject_en) begin
          code_p1 <= head_code_p0 ^ inject_mask(inj_idx);
          inj_idx <= (inj_idx == 3'd6) ? 3'd0 : inj_idx + 3'd1;
        end else begin
          code_p1 <= head_code_p0;
        end
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_encoder_proj.sv
// Randomized and directed bench for encoder_proj, checked against a scoreboard
// whose reference encoder builds the codeword from Hamming position coverage.
module tb_encoder_proj;
  localparam int DEPTH = 4;

  logic                   clock;
  logic                   reset;
  logic                   inject_en;
  logic [15:0]            word_count;
  logic [$clog2(DEPTH):0] fifo_level;

  encoder_proj_if bus ();

  encoder_proj #(.DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .inject_en  (inject_en),
    .word_count (word_count),
    .fifo_level (fifo_level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [3:0]  sb_q [$];
  logic [6:0]  em_q [$];
  int          midx = 0;
  bit          inj_mode = 0;
  logic [15:0] wc_m = '0;
  int          fires = 0;
  int          accepted = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Parity bit at position 2^k covers every position whose index has bit k set
  function automatic logic [6:0] ref_enc(input logic [3:0] d);
    logic [7:1] pos;
    int dpos [4] = '{3, 5, 6, 7};
    logic par;
    pos = '0;
    for (int i = 0; i < 4; i++) pos[dpos[i]] = d[i];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int j = 1; j <= 7; j++)
        if (((j >> k) & 1) == 1 && j != (1 << k)) par ^= pos[j];
      pos[1 << k] = par;
    end
    return pos[7:1];
  endfunction

  task automatic step(input logic iv, input logic [3:0] d, input logic ordy, input logic inj);
    logic in_fire, out_fire, hold;
    logic [6:0] prev, exp;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
    inject_en     = inj;
    in_fire  = iv && bus.in_ready && !reset;
    out_fire = bus.out_valid && ordy && !reset;
    hold     = bus.out_valid && !ordy && !reset;
    prev     = bus.io_out;
    if (out_fire) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        exp = ref_enc(sb_q.pop_front());
        if (inj_mode) begin
          exp = exp ^ 7'(1 << midx);
          midx = (midx + 1) % 7;
        end
        chk("codeword", 32'(bus.io_out), 32'(exp));
      end
      em_q.push_back(bus.io_out);
      wc_m++;
      fires++;
    end
    if (in_fire) begin
      sb_q.push_back(d);
      accepted++;
    end
    @(posedge clock);
    @(negedge clock);
    if (reset) begin
      sb_q.delete();
      midx = 0;
      wc_m = '0;
    end
    if (hold) begin
      chk("hold_data", 32'(bus.io_out), 32'(prev));
      chk("hold_valid", 32'(bus.out_valid), 1);
    end
    chk("level_max", 32'(fifo_level <= DEPTH), 1);
    chk("occupancy", 32'(fifo_level) + 32'(bus.out_valid), sb_q.size());
    chk("word_count", 32'(word_count), 32'(wc_m));
  endtask

  task automatic drain(input logic inj);
    int n = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && n < 50) begin
      step(1'b0, 4'h0, 1'b1, inj);
      n++;
    end
    chk("drain", sb_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] enc_exp [4];
    logic [6:0] inj_exp [8];
    logic [3:0] enc_in [4];
    int n;
    enc_in  = '{4'b0000, 4'b0001, 4'b1011, 4'b1111};
    enc_exp = '{7'b0000000, 7'b0000111, 7'b1010101, 7'b1111111};
    inj_exp = '{7'b0000001, 7'b0000010, 7'b0000100, 7'b0001000,
                7'b0010000, 7'b0100000, 7'b1000000, 7'b0000001};
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; inject_en = 1'b0;
    @(negedge clock);
    do_reset();
    chk("rst_io_out", 32'(bus.io_out), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_level", 32'(fifo_level), 0);

    // Encoding and latency
    em_q.delete();
    step(1'b1, enc_in[0], 1'b1, 1'b0);
    chk("lat_n_valid", 32'(bus.out_valid), 0);
    chk("lat_n_level", 32'(fifo_level), 1);
    step(1'b1, enc_in[1], 1'b1, 1'b0);
    chk("lat_n1_valid", 32'(bus.out_valid), 1);
    chk("lat_n1_code", 32'(bus.io_out), 0);
    step(1'b1, enc_in[2], 1'b1, 1'b0);
    step(1'b1, enc_in[3], 1'b1, 1'b0);
    drain(1'b0);
    chk("enc_count", em_q.size(), 4);
    for (int i = 0; i < 4 && i < em_q.size(); i++) chk("enc_literal", 32'(em_q[i]), 32'(enc_exp[i]));
    chk("enc_word_count", 32'(word_count), 4);

    // Backpressure
    do_reset();
    accepted = 0;
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0);
    chk("bp_accepted", accepted, DEPTH + 1);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_level", 32'(fifo_level), DEPTH);
    if (sb_q.size() > 0) chk("bp_frozen_first", 32'(bus.io_out), 32'(ref_enc(sb_q[0])));
    em_q.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk("bp_release_valid", 32'(bus.out_valid), 1);
      step(1'b0, 4'h0, 1'b1, 1'b0);
    end
    chk("bp_release_count", em_q.size(), DEPTH + 1);
    chk("bp_release_empty", 32'(bus.out_valid), 0);

    // Injection walk, then idle cycles with inject held must not advance the index
    do_reset();
    inj_mode = 1;
    em_q.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 1'b1, 1'b1);
    drain(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 1'b1);
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    drain(1'b1);
    chk("inj_count", em_q.size(), 9);
    for (int i = 0; i < 8 && i < em_q.size(); i++) chk("inj_literal", 32'(em_q[i]), 32'(inj_exp[i]));
    if (em_q.size() == 9) chk("inj_idle_hold", 32'(em_q[8]), 32'(7'b0000010));
    inj_mode = 0;

    // Reset mid-stream
    for (int i = 0; i < 4; i++) step(1'b1, 4'($urandom), 1'b0, 1'b0);
    chk("mid_valid", 32'(bus.out_valid), 1);
    chk("mid_level", 32'(fifo_level), 3);
    do_reset();
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_level", 32'(fifo_level), 0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_io_out", 32'(bus.io_out), 0);
    chk("mid_rst_count", 32'(word_count), 0);
    inj_mode = 1;
    em_q.delete();
    step(1'b1, 4'b0000, 1'b1, 1'b1);
    drain(1'b1);
    chk("inj_restart_n", em_q.size(), 1);
    if (em_q.size() == 1) chk("inj_restart", 32'(em_q[0]), 32'(7'b0000001));
    inj_mode = 0;

    // Counter wrap
    do_reset();
    fires = 0;
    n = 0;
    while (fires < 65537 && n < 70000) begin
      step(1'b1, 4'($urandom), 1'b1, 1'b0);
      n++;
    end
    chk("wrap_fires", fires, 65537);
    chk("wrap_count", 32'(word_count), 32'h0001);
    drain(1'b0);

    // Random valid/ready traffic
    for (int i = 0; i < 10000; i++) begin
      if (i < 5000) step(1'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      else          step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 3) == 0, 1'b0);
    end
    drain(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
